dcpu_bus_arb: RTL and testbench
===============================

DCPU_BUS_ARB -- requirements
Module: dcpu_bus_arb

Interface
REQ-001 Parameter TIMEOUT, default 15: the maximum number of wait cycles in a grant state before the arbiter aborts the access.
REQ-002 Parameter ERR_DATA, default 16'hDEAD: the read data returned to a master when its access aborts.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_m0_addr, i_m0_dat  in  16 each  master 0 (CPU) address and write data.
REQ-006 i_m0_we, i_m0_cs  in  1 each  master 0 write enable and request; cs is held until ack.
REQ-007 o_m0_dat  out  16 / o_m0_ack  out  1  read data and ack returned to master 0.
REQ-008 i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs, o_m1_dat, o_m1_ack: master 1 (DMA/debug) port, same widths and meaning as master 0.
REQ-009 o_s_addr, o_s_dat  out  16 each / o_s_we, o_s_cs  out  1 each  shared memory-bus request.
REQ-010 i_s_dat  in  16 / i_s_ack  in  1  shared-bus read data and ack.
REQ-011 o_gnt  out  2  one-hot current grant (bit0 = master 0, bit1 = master 1); 2'b00 when idle.
REQ-012 o_err  out  1  one-cycle pulse when an access times out.

Function
REQ-013 States: IDLE, GNT0, GNT1; the state register updates on the rising edge of i_clk.
REQ-014 Priority pointer prio: a 1-bit register naming the favoured master.
REQ-015 IDLE, no cs asserted: stay in IDLE.
REQ-016 IDLE, exactly one cs asserted: go to that master's GNT state.
REQ-017 IDLE, both cs asserted: go to GNT[prio].
REQ-018 Grant latency is exactly 1 cycle from cs assertion seen in IDLE to the grant state.
REQ-019 In GNTx, the slave outputs combinationally mirror master x: addr, dat, we, and cs.
REQ-020 In GNTx, o_mx_dat = i_s_dat and o_mx_ack = i_s_ack & i_mx_cs, both combinational.
REQ-021 The non-granted master sees dat = 0 and ack = 0.
REQ-022 In IDLE, all slave outputs are 0, both master acks are 0, and both master dats are 0.
REQ-023 Completion is i_s_ack & i_mx_cs in GNTx; on completion the next state is IDLE and prio is set to the other master.
REQ-024 Every access therefore costs at least one IDLE cycle before the next grant.
REQ-025 Abandon is i_mx_cs deasserted in GNTx without ack; the next state is IDLE and prio is unchanged.
REQ-026 i_s_ack while in IDLE, or during the non-granted master's request, is ignored and not forwarded.
REQ-027 A wait counter (width ceil(log2(TIMEOUT+1))) clears on entry to any GNT state.
REQ-028 The wait counter increments each GNT cycle that has no completion and no abandon.
REQ-029 Timeout: the counter equals TIMEOUT in GNTx without i_s_ack.
REQ-030 In the timeout cycle: o_s_cs = 0, o_mx_ack = 1, o_mx_dat = ERR_DATA, and o_err = 1.
REQ-031 After a timeout, the next state is IDLE and prio is set to the other master.
REQ-032 i_s_ack in the timeout cycle takes precedence: a normal completion occurs and o_err = 0.
REQ-033 o_gnt reflects the registered state only; it is never combinational on cs.
REQ-034 A single master requesting back-to-back is granted every second cycle regardless of prio.

Reset
REQ-035 Assertion of i_reset_n low forces state to IDLE, prio to 0, and the counter to 0 immediately, without waiting for a clock edge.
REQ-036 During reset, all outputs are 0: o_s_cs, o_s_we, o_s_addr, o_s_dat, both acks, both dats, o_gnt, and o_err.
REQ-037 Reset asserted mid-access drops o_s_cs in the same cycle; no ack is forwarded.
REQ-038 Deassertion is synchronised externally; the first edge after release evaluates IDLE arbitration.

Verification
REQ-039 After reset, assert m0 and m1 cs together; slave acks on the first grant cycle -> GNT0 first with o_m0_ack = 1, then IDLE, then GNT1.
REQ-040 With m1 cs = 0, issue m0 read at addr 0x0010 with i_s_dat = 0x1234 and ack after 2 wait cycles -> o_s_addr = 0x0010, o_m0_dat = 0x1234, o_m0_ack only in the ack cycle, and o_m1_ack = 0 throughout.
REQ-041 Issue m1 write at addr 0x8000 with data 0x00AA while m0 is idle -> o_s_we = 1, o_s_dat = 0x00AA, and o_gnt = 2'b10 for the duration.
REQ-042 Keep i_s_ack = 0 with TIMEOUT = 15 -> o_err pulses on the 16th GNT0 cycle, o_m0_dat = 0xDEAD, o_s_cs = 0 that cycle, and the next state is IDLE.
REQ-043 Pull i_reset_n low during GNT1 with m1 cs held -> o_s_cs and o_gnt go to 0 asynchronously; after release with both requesting, m0 is granted first.
REQ-044 m0 drops cs in GNT0 without ack while m1 is requesting -> IDLE, then GNT1, with no ack pulse to m0.

Source files
------------

// File: rtl/dcpu_bus_arb_if.sv
// Signal bundle for the two-master / one-slave memory bus arbiter.
// Names carry the arbiter's point of view: i_ = into the arbiter, o_ = out of it.
interface dcpu_bus_arb_if;
  logic [15:0] i_m0_addr;
  logic [15:0] i_m0_dat;
  logic        i_m0_we;
  logic        i_m0_cs;
  logic [15:0] o_m0_dat;
  logic        o_m0_ack;
  logic [15:0] i_m1_addr;
  logic [15:0] i_m1_dat;
  logic        i_m1_we;
  logic        i_m1_cs;
  logic [15:0] o_m1_dat;
  logic        o_m1_ack;
  logic [15:0] o_s_addr;
  logic [15:0] o_s_dat;
  logic        o_s_we;
  logic        o_s_cs;
  logic [15:0] i_s_dat;
  logic        i_s_ack;
  logic [1:0]  o_gnt;
  logic        o_err;

  modport slave (
    input  i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
    input  i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
    input  i_s_dat, i_s_ack,
    output o_m0_dat, o_m0_ack, o_m1_dat, o_m1_ack,
    output o_s_addr, o_s_dat, o_s_we, o_s_cs, o_gnt, o_err
  );

  modport master (
    output i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
    output i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
    output i_s_dat, i_s_ack,
    input  o_m0_dat, o_m0_ack, o_m1_dat, o_m1_ack,
    input  o_s_addr, o_s_dat, o_s_we, o_s_cs, o_gnt, o_err
  );
endinterface

// File: rtl/dcpu_bus_arb.sv
// Round-robin arbiter sharing one memory bus between the CPU (m0) and DMA/debug (m1),
// with a wait-cycle watchdog that aborts a stalled access and returns ERR_DATA.
module dcpu_bus_arb #(
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  dcpu_bus_arb_if.slave  bus
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_prio;
  logic          w_prio_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_sel;
  logic [15:0]   w_addr;
  logic [15:0]   w_dat;
  logic          w_we;
  logic          w_cs;
  logic          w_done;
  logic          w_tmo;

  // Select the granted master's request and classify the cycle outcome
  always_comb begin
    w_sel  = (r_state == GNT1);
    w_addr = w_sel ? bus.i_m1_addr : bus.i_m0_addr;
    w_dat  = w_sel ? bus.i_m1_dat  : bus.i_m0_dat;
    w_we   = w_sel ? bus.i_m1_we   : bus.i_m0_we;
    w_cs   = w_sel ? bus.i_m1_cs   : bus.i_m0_cs;
    if (r_state != IDLE) begin
      w_done = w_cs & bus.i_s_ack;
      // a slave ack in the last allowed cycle wins over the watchdog
      w_tmo  = w_cs & ~bus.i_s_ack & (r_cnt == CW'(TIMEOUT));
    end else begin
      w_done = 1'b0;
      w_tmo  = 1'b0;
    end
  end

  // Next state, priority pointer and wait counter
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    case (r_state)
      IDLE: begin
        if (bus.i_m0_cs && bus.i_m1_cs) begin
          w_state_nxt = r_prio ? GNT1 : GNT0;
        end else if (bus.i_m0_cs) begin
          w_state_nxt = GNT0;
        end else if (bus.i_m1_cs) begin
          w_state_nxt = GNT1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (!w_cs) begin
          w_state_nxt = IDLE;
        end else if (w_done || w_tmo) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = ~w_sel;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if ((r_state != IDLE) && (w_state_nxt != IDLE)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // State, priority and counter registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Bus steering: slave mirrors the granted master, the other master sees zeros
  always_comb begin
    bus.o_s_addr = 16'h0000;
    bus.o_s_dat  = 16'h0000;
    bus.o_s_we   = 1'b0;
    bus.o_s_cs   = 1'b0;
    bus.o_m0_dat = 16'h0000;
    bus.o_m0_ack = 1'b0;
    bus.o_m1_dat = 16'h0000;
    bus.o_m1_ack = 1'b0;
    bus.o_err    = 1'b0;
    bus.o_gnt    = r_state;
    if (r_state != IDLE) begin
      bus.o_s_addr = w_addr;
      bus.o_s_dat  = w_dat;
      bus.o_s_we   = w_we;
      bus.o_s_cs   = w_cs & ~w_tmo;
      bus.o_err    = w_tmo;
      if (w_sel) begin
        bus.o_m1_dat = w_tmo ? ERR_DATA : bus.i_s_dat;
        bus.o_m1_ack = w_done | w_tmo;
      end else begin
        bus.o_m0_dat = w_tmo ? ERR_DATA : bus.i_s_dat;
        bus.o_m0_ack = w_done | w_tmo;
      end
    end else begin
      bus.o_s_cs   = 1'b0;
    end
  end
endmodule

// File: tb/tb_dcpu_bus_arb.sv
// Directed bench for dcpu_bus_arb: stimulus pushes expected master responses,
// a negedge monitor pops and compares them whenever an ack or error appears.
module tb_dcpu_bus_arb;
  logic i_clk;
  logic i_reset_n;
  dcpu_bus_arb_if bus ();

  dcpu_bus_arb #(.TIMEOUT(15), .ERR_DATA(16'hDEAD)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [1:0]  ack;
    logic [15:0] dat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] ack, input logic [15:0] dat, input logic err);
    exp_t e;
    e.ack = ack;
    e.dat = dat;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge i_clk);
  endtask

  // Monitor: every ack/err pulse must match the oldest expected response
  always @(negedge i_clk) begin
    if (i_reset_n && (bus.o_m0_ack || bus.o_m1_ack || bus.o_err)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mon_unexpected: ack=%b%b err=%b with nothing expected (t=%0t)",
                 bus.o_m1_ack, bus.o_m0_ack, bus.o_err, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_ack", {30'd0, bus.o_m1_ack, bus.o_m0_ack}, {30'd0, e.ack});
        chk("mon_m0_dat", {16'd0, bus.o_m0_dat}, (e.ack == 2'b01) ? {16'd0, e.dat} : 32'd0);
        chk("mon_m1_dat", {16'd0, bus.o_m1_dat}, (e.ack == 2'b10) ? {16'd0, e.dat} : 32'd0);
        chk("mon_err", {31'd0, bus.o_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0;
    bus.i_m0_addr = 16'h0000; bus.i_m0_dat = 16'h0000; bus.i_m0_we = 1'b0; bus.i_m0_cs = 1'b0;
    bus.i_m1_addr = 16'h0000; bus.i_m1_dat = 16'h0000; bus.i_m1_we = 1'b0; bus.i_m1_cs = 1'b0;
    bus.i_s_dat = 16'h0000; bus.i_s_ack = 1'b0;
    step(); step();
    neg();
    chk("rst_gnt", {30'd0, bus.o_gnt}, 32'd0);
    chk("rst_s_cs", {31'd0, bus.o_s_cs}, 32'd0);
    chk("rst_err", {31'd0, bus.o_err}, 32'd0);
    chk("rst_acks", {30'd0, bus.o_m1_ack, bus.o_m0_ack}, 32'd0);

    // both request together: m0 first, then m1
    step(); i_reset_n = 1'b1;
    bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h0100; bus.i_m1_cs = 1'b1; bus.i_m1_addr = 16'h0200;
    neg(); chk("t1_idle_gnt", {30'd0, bus.o_gnt}, 32'd0);
    step(); bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h1111; push(2'b01, 16'h1111, 1'b0);
    neg(); chk("t1_gnt0", {30'd0, bus.o_gnt}, 32'd1);
    step(); bus.i_m0_cs = 1'b0; bus.i_s_ack = 1'b0;
    neg(); chk("t1_idle_between", {30'd0, bus.o_gnt}, 32'd0);
    step(); bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h2222; push(2'b10, 16'h2222, 1'b0);
    neg(); chk("t1_gnt1", {30'd0, bus.o_gnt}, 32'd2);
    step(); bus.i_m1_cs = 1'b0; bus.i_s_ack = 1'b0;
    neg(); chk("t1_back_idle", {30'd0, bus.o_gnt}, 32'd0);

    // stray slave ack in IDLE is ignored; then m0 read with two wait cycles
    step(); bus.i_s_ack = 1'b1; bus.i_s_dat = 16'hFFFF;
    neg(); chk("t2_idle_s_cs", {31'd0, bus.o_s_cs}, 32'd0);
    step(); bus.i_s_ack = 1'b0; bus.i_m0_cs = 1'b1; bus.i_m0_we = 1'b0; bus.i_m0_addr = 16'h0010;
    neg();
    step();
    neg();
    chk("t2_s_addr", {16'd0, bus.o_s_addr}, 32'h0010);
    chk("t2_gnt", {30'd0, bus.o_gnt}, 32'd1);
    chk("t2_s_cs", {31'd0, bus.o_s_cs}, 32'd1);
    step();
    neg();
    step(); bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h1234; push(2'b01, 16'h1234, 1'b0);
    neg();
    step(); bus.i_m0_cs = 1'b0; bus.i_s_ack = 1'b0;
    neg(); chk("t2_idle", {30'd0, bus.o_gnt}, 32'd0);

    // m1 write
    step(); bus.i_m1_cs = 1'b1; bus.i_m1_we = 1'b1; bus.i_m1_addr = 16'h8000; bus.i_m1_dat = 16'h00AA;
    neg();
    step();
    neg();
    chk("t3_gnt", {30'd0, bus.o_gnt}, 32'd2);
    chk("t3_s_we", {31'd0, bus.o_s_we}, 32'd1);
    chk("t3_s_dat", {16'd0, bus.o_s_dat}, 32'h00AA);
    chk("t3_s_addr", {16'd0, bus.o_s_addr}, 32'h8000);
    step();
    neg(); chk("t3_gnt_wait", {30'd0, bus.o_gnt}, 32'd2);
    step(); bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h0000; push(2'b10, 16'h0000, 1'b0);
    neg(); chk("t3_gnt_ack", {30'd0, bus.o_gnt}, 32'd2);
    step(); bus.i_m1_cs = 1'b0; bus.i_m1_we = 1'b0; bus.i_s_ack = 1'b0;
    neg(); chk("t3_idle", {30'd0, bus.o_gnt}, 32'd0);

    // timeout on the 16th GNT0 cycle
    step(); bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h0020;
    neg();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) push(2'b01, 16'hDEAD, 1'b1);
      neg();
      if (i == 16) chk("t4_tmo_s_cs", {31'd0, bus.o_s_cs}, 32'd0);
      if (i == 15) chk("t4_pre_tmo_s_cs", {31'd0, bus.o_s_cs}, 32'd1);
    end
    step(); bus.i_m0_cs = 1'b0;
    neg(); chk("t4_idle", {30'd0, bus.o_gnt}, 32'd0);

    // slave ack in the timeout cycle completes normally
    step(); bus.i_m0_cs = 1'b1;
    neg();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) begin
        bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h5A5A; push(2'b01, 16'h5A5A, 1'b0);
      end
      neg();
      if (i == 16) chk("t5_s_cs", {31'd0, bus.o_s_cs}, 32'd1);
    end
    step(); bus.i_m0_cs = 1'b0; bus.i_s_ack = 1'b0;
    neg(); chk("t5_idle", {30'd0, bus.o_gnt}, 32'd0);

    // m0 abandons while m1 waits
    step(); bus.i_m0_cs = 1'b1;
    neg();
    step(); bus.i_m1_cs = 1'b1; bus.i_m1_we = 1'b0; bus.i_m1_addr = 16'h0300;
    neg(); chk("t6_gnt0", {30'd0, bus.o_gnt}, 32'd1);
    step(); bus.i_m0_cs = 1'b0;
    neg(); chk("t6_gnt0_drop", {30'd0, bus.o_gnt}, 32'd1);
    step();
    neg(); chk("t6_idle", {30'd0, bus.o_gnt}, 32'd0);
    step();
    neg();
    chk("t6_gnt1", {30'd0, bus.o_gnt}, 32'd2);
    chk("t6_s_cs", {31'd0, bus.o_s_cs}, 32'd1);
    chk("t6_s_addr", {16'd0, bus.o_s_addr}, 32'h0300);

    // asynchronous reset during GNT1
    #2; i_reset_n = 1'b0;
    #1;
    chk("t7_rst_s_cs", {31'd0, bus.o_s_cs}, 32'd0);
    chk("t7_rst_gnt", {30'd0, bus.o_gnt}, 32'd0);
    chk("t7_rst_ack", {31'd0, bus.o_m1_ack}, 32'd0);
    bus.i_m0_cs = 1'b1;
    step(); step(); i_reset_n = 1'b1;
    neg(); chk("t7_release_idle", {30'd0, bus.o_gnt}, 32'd0);
    step(); bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h7777; push(2'b01, 16'h7777, 1'b0);
    neg(); chk("t7_gnt0_first", {30'd0, bus.o_gnt}, 32'd1);
    step(); bus.i_m0_cs = 1'b0; bus.i_s_ack = 1'b0;
    neg();
    step(); bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h8888; push(2'b10, 16'h8888, 1'b0);
    neg(); chk("t7_gnt1", {30'd0, bus.o_gnt}, 32'd2);
    step(); bus.i_m1_cs = 1'b0; bus.i_s_ack = 1'b0;
    neg();

    // single master back-to-back: granted every second cycle
    step(); bus.i_m1_cs = 1'b1; bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h0B0B;
    neg();
    for (int i = 0; i < 4; i++) begin
      step();
      if ((i % 2) == 0) push(2'b10, 16'h0B0B, 1'b0);
      if (i == 3) begin
        bus.i_m1_cs = 1'b0; bus.i_s_ack = 1'b0;
      end
      neg();
      chk("t8_b2b_gnt", {30'd0, bus.o_gnt}, ((i % 2) == 0) ? 32'd2 : 32'd0);
    end

    step(); step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
